// File: rtl/sdram_pkg.sv
// Shared types and helpers for the ping-pong SDRAM burst writer: drain FSM
// encoding, bank tag layout and the frame/address sizing functions.
package sdram_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_REQ   = 2'd1,
    DRAIN_WRITE = 2'd2,
    DRAIN_DONE  = 2'd3
  } drain_state_e;

  // Wide enough for the largest supported ring (4 frames).
  localparam int FRAME_IDX_W = 2;

  typedef struct packed {
    logic                   last;
    logic [FRAME_IDX_W-1:0] frame;
  } bank_tag_t;

  function automatic int frame_words(input int width, input int height);
    return width * height;
  endfunction

  // Bits needed to address every word of every frame in the ring.
  function automatic int addr_bits_needed(input longint base, input int nf, input int fw);
    return $clog2(base + longint'(nf) * longint'(fw));
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_burst_bank.sv
// One staging bank: BURST_LEN words of pixel storage with a write port,
// a combinational read mux and the {address, tag} recorded when it fills.
module sdram_burst_bank
  import sdram_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int W      = 16,
  parameter int ADDR_W = 24,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [W-1:0]      wr_data,
  input  logic              tag_en,
  input  logic [ADDR_W-1:0] tag_addr_in,
  input  bank_tag_t         tag_in,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [W-1:0]      rd_data,
  output logic [ADDR_W-1:0] tag_addr,
  output bank_tag_t         tag
);

  logic [W-1:0]      mem_q [DEPTH];
  logic [W-1:0]      mem_d [DEPTH];
  logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
  bank_tag_t         tag_q, tag_d;

  always_comb begin
    mem_d      = mem_q;
    tag_addr_d = tag_addr_q;
    tag_d      = tag_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
    if (tag_en) begin
      tag_addr_d = tag_addr_in;
      tag_d      = tag_in;
    end
  end

  // Contents are only meaningful while the owner marks the bank full.
  always_ff @(posedge CLK) begin
    mem_q      <= mem_d;
    tag_addr_q <= tag_addr_d;
    tag_q      <= tag_d;
  end

  assign rd_data  = mem_q[rd_idx];
  assign tag_addr = tag_addr_q;
  assign tag      = tag_q;

endmodule

// File: rtl/sdram_burst_writer.sv
// Packs a valid/ready pixel stream into BURST_LEN-word bursts through two
// ping-pong banks and writes them into a ring of NUM_FRAMES SDRAM frames.
module sdram_burst_writer
  import sdram_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int BURST_LEN    = 8,
  parameter int PIXEL_W      = 16,
  parameter int ADDR_W       = 24,
  parameter int NUM_FRAMES   = 2,
  parameter int BASE_ADDR    = 0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            i_pix_valid,
  output logic                            o_pix_ready,
  input  logic [PIXEL_W-1:0]              i_pixel,
  input  logic                            i_sof,
  output logic                            o_sdram_req,
  input  logic                            i_sdram_ack,
  input  logic                            i_sdram_valid_wr,
  output logic [PIXEL_W-1:0]              o_sdram_pixel,
  output logic [ADDR_W-1:0]               o_sdram_addr,
  output logic                            o_bursting,
  output logic                            o_frame_done,
  output logic [idx_w(NUM_FRAMES)-1:0]    o_frame_idx,
  output logic                            o_resync
);

  localparam int FRAME_WORDS = frame_words(FRAME_WIDTH, FRAME_HEIGHT);
  localparam int CNT_W       = $clog2(BURST_LEN);
  localparam int OFF_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int OIDX_W      = idx_w(NUM_FRAMES);

  if (addr_bits_needed(BASE_ADDR, NUM_FRAMES, FRAME_WORDS) > ADDR_W) begin : g_addr_chk
    $error("sdram_burst_writer: frame ring does not fit in ADDR_W bits");
  end
  if ((BURST_LEN < 2) || ((BURST_LEN & (BURST_LEN - 1)) != 0) ||
      ((FRAME_WORDS % BURST_LEN) != 0)) begin : g_burst_chk
    $error("sdram_burst_writer: BURST_LEN must be a power of 2 >= 2 dividing the frame");
  end
  if ((NUM_FRAMES < 1) || (NUM_FRAMES > 4)) begin : g_frames_chk
    $error("sdram_burst_writer: NUM_FRAMES must be 1..4");
  end

  drain_state_e           state_q, state_d;
  logic                   fill_sel_q, fill_sel_d, drain_sel_q, drain_sel_d;
  logic [CNT_W-1:0]       count_q, count_d, beat_q, beat_d;
  logic [OFF_W-1:0]       offset_q, offset_d;
  logic [FRAME_IDX_W-1:0] fill_frame_q, fill_frame_d;
  logic [1:0]             full_q, full_d, full_set, full_clr;
  logic                   req_q, req_d, bursting_q, bursting_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [PIXEL_W-1:0]     pixel_q, pixel_d;
  logic                   frame_done_q, frame_done_d, resync_q, resync_d;
  logic [OIDX_W-1:0]      frame_idx_q, frame_idx_d;

  logic [1:0]             bank_wr_en, bank_tag_en;
  logic [CNT_W-1:0]       wr_idx, rd_idx;
  logic [ADDR_W-1:0]      fill_addr;
  bank_tag_t              fill_tag;
  logic [PIXEL_W-1:0]     bank_rd   [2];
  logic [ADDR_W-1:0]      bank_addr [2];
  bank_tag_t              bank_tag  [2];
  logic                   pix_accept, frame_end;
  logic                   unused_tag_frame;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sdram_burst_bank #(
      .DEPTH(BURST_LEN), .W(PIXEL_W), .ADDR_W(ADDR_W), .IDX_W(CNT_W)
    ) u_bank (
      .CLK        (CLK),
      .wr_en      (bank_wr_en[b]),
      .wr_idx     (wr_idx),
      .wr_data    (i_pixel),
      .tag_en     (bank_tag_en[b]),
      .tag_addr_in(fill_addr),
      .tag_in     (fill_tag),
      .rd_idx     (rd_idx),
      .rd_data    (bank_rd[b]),
      .tag_addr   (bank_addr[b]),
      .tag        (bank_tag[b])
    );
  end

  // Pixel handshake: a pixel transfers on any cycle with valid && ready; ready
  // depends only on registered state, so the source may hold valid and data.
  assign o_pix_ready = !full_q[fill_sel_q];
  assign pix_accept  = i_pix_valid && o_pix_ready;
  assign frame_end   = (int'(offset_q) + BURST_LEN) == FRAME_WORDS;
  assign fill_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(fill_frame_q) * ADDR_W'(FRAME_WORDS)
                     + ADDR_W'(offset_q);

  always_comb begin
    fill_sel_d   = fill_sel_q;
    count_d      = count_q;
    offset_d     = offset_q;
    fill_frame_d = fill_frame_q;
    full_set     = '0;
    bank_wr_en   = '0;
    bank_tag_en  = '0;
    wr_idx       = count_q;
    resync_d     = 1'b0;
    fill_tag     = '{last: 1'b0, frame: fill_frame_q};
    if (pix_accept) begin
      bank_wr_en[fill_sel_q] = 1'b1;
      if (i_sof && ((count_q != '0) || (offset_q != '0))) begin
        // Restart the aborted frame in place; the sof pixel becomes word 0.
        wr_idx   = '0;
        count_d  = CNT_W'(1);
        offset_d = '0;
        resync_d = 1'b1;
      end else if (count_q == CNT_W'(BURST_LEN - 1)) begin
        full_set[fill_sel_q]    = 1'b1;
        bank_tag_en[fill_sel_q] = 1'b1;
        count_d                 = '0;
        fill_sel_d              = !fill_sel_q;
        if (frame_end) begin
          fill_tag.last = 1'b1;
          offset_d      = '0;
          fill_frame_d  = (fill_frame_q == FRAME_IDX_W'(NUM_FRAMES - 1)) ? '0
                        : fill_frame_q + FRAME_IDX_W'(1);
        end else begin
          offset_d = offset_q + OFF_W'(BURST_LEN);
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_sel_d  = drain_sel_q;
    beat_d       = beat_q;
    req_d        = req_q;
    bursting_d   = bursting_q;
    addr_d       = addr_q;
    pixel_d      = pixel_q;
    frame_done_d = 1'b0;
    frame_idx_d  = frame_idx_q;
    full_clr     = '0;
    rd_idx       = (state_q == DRAIN_IDLE) ? '0 : beat_q + CNT_W'(1);
    case (state_q)
      DRAIN_IDLE: begin
        if (full_q[drain_sel_q]) begin
          addr_d  = bank_addr[drain_sel_q];
          pixel_d = bank_rd[drain_sel_q];
          beat_d  = '0;
          req_d   = 1'b1;
          state_d = DRAIN_REQ;
        end
      end
      DRAIN_REQ: begin
        if (i_sdram_ack) begin
          req_d      = 1'b0;
          bursting_d = 1'b1;
          state_d    = DRAIN_WRITE;
        end
      end
      DRAIN_WRITE: begin
        if (i_sdram_valid_wr) begin
          if (beat_q == CNT_W'(BURST_LEN - 1)) begin
            bursting_d = 1'b0;
            state_d    = DRAIN_DONE;
          end else begin
            beat_d  = beat_q + CNT_W'(1);
            pixel_d = bank_rd[drain_sel_q];
          end
        end
      end
      DRAIN_DONE: begin
        bursting_d            = 1'b0;
        full_clr[drain_sel_q] = 1'b1;
        drain_sel_d           = !drain_sel_q;
        if (bank_tag[drain_sel_q].last) begin
          frame_done_d = 1'b1;
          frame_idx_d  = bank_tag[drain_sel_q].frame[OIDX_W-1:0];
        end
        state_d = DRAIN_IDLE;
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  // Set and clear always target different banks, so they never collide.
  assign full_d = (full_q | full_set) & ~full_clr;
  assign unused_tag_frame = ^{bank_tag[0].frame, bank_tag[1].frame};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= DRAIN_IDLE;
      fill_sel_q   <= 1'b0;
      drain_sel_q  <= 1'b0;
      count_q      <= '0;
      beat_q       <= '0;
      offset_q     <= '0;
      fill_frame_q <= '0;
      full_q       <= '0;
      req_q        <= 1'b0;
      bursting_q   <= 1'b0;
      addr_q       <= '0;
      pixel_q      <= '0;
      frame_done_q <= 1'b0;
      frame_idx_q  <= '0;
      resync_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_sel_q   <= fill_sel_d;
      drain_sel_q  <= drain_sel_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      offset_q     <= offset_d;
      fill_frame_q <= fill_frame_d;
      full_q       <= full_d;
      req_q        <= req_d;
      bursting_q   <= bursting_d;
      addr_q       <= addr_d;
      pixel_q      <= pixel_d;
      frame_done_q <= frame_done_d;
      frame_idx_q  <= frame_idx_d;
      resync_q     <= resync_d;
    end
  end

  assign o_sdram_req   = req_q;
  assign o_bursting    = bursting_q;
  assign o_sdram_addr  = addr_q;
  assign o_sdram_pixel = pixel_q;
  assign o_frame_done  = frame_done_q;
  assign o_frame_idx   = frame_idx_q;
  assign o_resync      = resync_q;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Bench for sdram_burst_writer: 4x4 frames, 8-word bursts, 2-frame ring at 0x100,
// with a pixel source, an SDRAM write-port emulator and a burst-level reference model.
module tb_sdram_burst_writer;

  localparam int FW   = 16;
  localparam int BL   = 8;
  localparam int NF   = 2;
  localparam int BASE = 32'h100;
  localparam int PW   = 16;
  localparam int AW   = 24;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          i_pix_valid = 1'b0;
  logic          o_pix_ready;
  logic [PW-1:0] i_pixel = '0;
  logic          i_sof = 1'b0;
  logic          o_sdram_req;
  logic          i_sdram_ack = 1'b0;
  logic          i_sdram_valid_wr = 1'b0;
  logic [PW-1:0] o_sdram_pixel;
  logic [AW-1:0] o_sdram_addr;
  logic          o_bursting;
  logic          o_frame_done;
  logic [0:0]    o_frame_idx;
  logic          o_resync;

  sdram_burst_writer #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(4), .BURST_LEN(BL), .PIXEL_W(PW),
    .ADDR_W(AW), .NUM_FRAMES(NF), .BASE_ADDR(BASE)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .i_pixel(i_pixel), .i_sof(i_sof),
    .o_sdram_req(o_sdram_req), .i_sdram_ack(i_sdram_ack), .i_sdram_valid_wr(i_sdram_valid_wr),
    .o_sdram_pixel(o_sdram_pixel), .o_sdram_addr(o_sdram_addr), .o_bursting(o_bursting),
    .o_frame_done(o_frame_done), .o_frame_idx(o_frame_idx), .o_resync(o_resync)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Scoreboard state
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [PW-1:0] exp_q[$];
  int            exp_addr[$];
  bit            exp_last[$];
  int            exp_frame[$];
  int            exp_done[$];
  logic [PW-1:0] m_part[$];
  int            m_off, m_frame;
  bit            exp_resync;
  logic [PW-1:0] src_pix[$];
  bit            src_sof[$];
  logic [PW-1:0] cap_q[$];
  logic [AW-1:0] cur_addr;
  int            addr_log[$];
  int            done_log[$];
  logic [PW-1:0] first_log[$];
  int            n_acc, n_resync;
  bit            ack_hold, ack_rand, wr_rand, valid_rand;
  int            wr_budget = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_part.delete(); m_off = 0; m_frame = 0;
    exp_q.delete(); exp_addr.delete(); exp_last.delete(); exp_frame.delete(); exp_done.delete();
    src_pix.delete(); src_sof.delete(); cap_q.delete();
    addr_log.delete(); done_log.delete(); first_log.delete();
    n_acc = 0; n_resync = 0;
  endtask

  // Reference: frame-level bookkeeping of pixels into bursts and addresses.
  task automatic model_accept(input logic [PW-1:0] pix, input bit sof);
    if (sof && (m_part.size() != 0 || m_off != 0)) begin
      m_part.delete();
      m_off = 0;
      exp_resync = 1'b1;
    end
    m_part.push_back(pix);
    if (m_part.size() == BL) begin
      exp_addr.push_back(BASE + m_frame * FW + m_off);
      foreach (m_part[i]) exp_q.push_back(m_part[i]);
      exp_last.push_back(m_off + BL == FW);
      exp_frame.push_back(m_frame);
      m_part.delete();
      if (m_off + BL == FW) begin
        m_off = 0;
        m_frame = (m_frame + 1) % NF;
      end else begin
        m_off += BL;
      end
    end
  endtask

  task automatic compare_burst();
    bit avail;
    avail = (exp_addr.size() != 0);
    check_eq("burst_expected", avail, 1);
    if (avail) begin
      check_eq("burst_addr", cur_addr, exp_addr.pop_front());
      for (int i = 0; i < BL; i++) check_eq("burst_word", cap_q[i], exp_q.pop_front());
      if (exp_last.pop_front()) exp_done.push_back(exp_frame.pop_front());
      else void'(exp_frame.pop_front());
    end
    addr_log.push_back(int'(cur_addr));
    first_log.push_back(cap_q[0]);
    cap_q.delete();
  endtask

  // Driver: one clock cycle of pixel source plus SDRAM write-port emulation.
  task automatic step();
    bit            acc, cons, ackn, in_sof;
    logic [PW-1:0] pre_pix, in_pix, tmp;
    logic [AW-1:0] pre_addr;
    acc      = RST && i_pix_valid && o_pix_ready;
    cons     = RST && i_sdram_valid_wr && o_bursting;
    ackn     = RST && i_sdram_ack && o_sdram_req;
    pre_pix  = o_sdram_pixel;
    pre_addr = o_sdram_addr;
    in_pix   = i_pixel;
    in_sof   = i_sof;
    exp_resync = 1'b0;
    @(posedge CLK); #1;
    if (acc) begin
      n_acc++;
      tmp = src_pix.pop_front();
      void'(src_sof.pop_front());
      model_accept(in_pix, in_sof);
    end
    if (ackn) cur_addr = pre_addr;
    if (cons) begin
      cap_q.push_back(pre_pix);
      if (wr_budget > 0) wr_budget--;
      if (cap_q.size() == BL) compare_burst();
    end
    check_eq("resync_pulse", o_resync, exp_resync);
    if (o_resync) n_resync++;
    if (o_frame_done) begin
      check_eq("frame_done_expected", exp_done.size() != 0, 1);
      if (exp_done.size() != 0) check_eq("frame_idx", o_frame_idx, exp_done.pop_front());
      done_log.push_back(int'(o_frame_idx));
    end
    if (!RST) begin
      i_pix_valid = 0; i_sof = 0; i_sdram_ack = 0; i_sdram_valid_wr = 0;
    end else begin
      if (src_pix.size() != 0) begin
        if (!(i_pix_valid && !acc))
          i_pix_valid = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_pixel = src_pix[0];
        i_sof   = src_sof[0];
      end else begin
        i_pix_valid = 0; i_sof = 0;
      end
      i_sdram_ack = !ack_hold && o_sdram_req && (ack_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      i_sdram_valid_wr = o_bursting && (wr_budget != 0) &&
                         (wr_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  endtask

  function automatic bit is_idle();
    return src_pix.size() == 0 && exp_addr.size() == 0 && cap_q.size() == 0 &&
           exp_done.size() == 0 && !o_bursting && !o_sdram_req;
  endfunction

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while (!is_idle() && n < max_cycles) begin
      step();
      n++;
    end
    check_eq("drain_complete", is_idle(), 1);
    repeat (6) step();
  endtask

  task automatic reset_dut();
    RST = 1'b0;
    model_reset();
    i_pix_valid = 0; i_sof = 0; i_sdram_ack = 0; i_sdram_valid_wr = 0;
    step();
    step();
    RST = 1'b1;
  endtask

  task automatic push_pix(input logic [PW-1:0] pix, input bit sof);
    src_pix.push_back(pix);
    src_sof.push_back(sof);
  endtask

  initial begin
    int exp_addrs[6];
    int n;
    exp_addrs = '{32'h100, 32'h108, 32'h110, 32'h118, 32'h100, 32'h108};

    // Reset values
    reset_dut();
    check_eq("rst_ready", o_pix_ready, 1);
    check_eq("rst_req", o_sdram_req, 0);
    check_eq("rst_bursting", o_bursting, 0);
    check_eq("rst_frame_done", o_frame_done, 0);
    check_eq("rst_frame_idx", o_frame_idx, 0);
    check_eq("rst_resync", o_resync, 0);
    check_eq("rst_addr", o_sdram_addr, 0);
    check_eq("rst_pixel", o_sdram_pixel, 0);

    // One frame of pixels 0..15, controller always ready
    ack_hold = 0; ack_rand = 0; wr_rand = 0; valid_rand = 0;
    for (int i = 0; i < 16; i++) push_pix(PW'(i), i == 0);
    run_until_idle(500);
    check_eq("t1_bursts", addr_log.size(), 2);
    check_eq("t1_addr0", addr_log[0], 32'h100);
    check_eq("t1_addr1", addr_log[1], 32'h108);
    check_eq("t1_done_count", done_log.size(), 1);
    check_eq("t1_done_idx", done_log[0], 0);
    for (int i = 0; i < 8; i++) push_pix(PW'(100 + i), 1'b0);
    run_until_idle(500);
    check_eq("t1_next_frame_addr", addr_log[2], 32'h110);

    // Back-pressure: ack withheld, both banks fill and input stalls
    reset_dut();
    ack_hold = 1;
    for (int i = 0; i < 20; i++) push_pix(PW'($urandom_range(0, 16'hFFFF)), 1'b0);
    repeat (40) step();
    check_eq("t2_accepted_while_held", n_acc, 16);
    check_eq("t2_ready_low", o_pix_ready, 0);
    ack_hold = 0;
    run_until_idle(500);
    check_eq("t2_accepted_total", n_acc, 20);

    // Three frames with random gaps: ring wrap
    reset_dut();
    ack_rand = 1; wr_rand = 1; valid_rand = 1;
    for (int i = 0; i < 48; i++) push_pix(PW'($urandom_range(0, 16'hFFFF)), (i % FW) == 0);
    run_until_idle(3000);
    check_eq("t3_bursts", addr_log.size(), 6);
    for (int i = 0; i < 6; i++) check_eq("t3_addr_seq", addr_log[i], exp_addrs[i]);
    check_eq("t3_done_count", done_log.size(), 3);
    check_eq("t3_done_idx0", done_log[0], 0);
    check_eq("t3_done_idx1", done_log[1], 1);
    check_eq("t3_done_idx2", done_log[2], 0);

    // Start-of-frame resync after a partial burst
    reset_dut();
    for (int i = 0; i < 5; i++) push_pix(PW'(16'hA0 + i), 1'b0);
    push_pix(16'h5A5A, 1'b1);
    for (int i = 0; i < 7; i++) push_pix(PW'(16'hC0 + i), 1'b0);
    run_until_idle(1000);
    check_eq("t4_resync_count", n_resync, 1);
    check_eq("t4_bursts", addr_log.size(), 1);
    check_eq("t4_addr", addr_log[0], 32'h100);
    check_eq("t4_first_word", first_log[0], 16'h5A5A);

    // Reset while presenting beat 3 of a burst
    reset_dut();
    ack_rand = 0; wr_rand = 0; valid_rand = 0;
    wr_budget = 3;
    for (int i = 0; i < 8; i++) push_pix(PW'(16'h300 + i), 1'b0);
    n = 0;
    while (cap_q.size() < 3 && n < 200) begin
      step();
      n++;
    end
    check_eq("t5_beats_before_rst", cap_q.size(), 3);
    check_eq("t5_bursting_before_rst", o_bursting, 1);
    RST = 1'b0;
    step();
    check_eq("t5_rst_bursting", o_bursting, 0);
    check_eq("t5_rst_req", o_sdram_req, 0);
    check_eq("t5_rst_ready", o_pix_ready, 1);
    model_reset();
    RST = 1'b1;
    wr_budget = -1;
    for (int i = 0; i < 8; i++) push_pix(PW'(16'h400 + i), 1'b0);
    run_until_idle(500);
    check_eq("t5_bursts", addr_log.size(), 1);
    check_eq("t5_addr_after_rst", addr_log[0], 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
